// File: rtl/rv32e_mem_responder.sv
// Memory/peripheral responder for a small RV32E core: program store with a streaming
// loader, data RAM, and an MMIO block holding GPIO, a free-running cycle counter and a TX byte FIFO.
module rv32e_mem_responder #(
  parameter int PROG_WORDS = 256,
  parameter int DATA_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] program_addr_bus,
  output logic [31:0] program_data_bus,
  input  logic [31:0] mem_addr_bus,
  input  logic [31:0] mem_write_data_bus,
  input  logic        mem_write_signal,
  output logic [31:0] mem_read_data_bus,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic        cpu_hold,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PAW = $clog2(PROG_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);

  localparam logic [1:0] SEL_GPIO   = 2'd0;
  localparam logic [1:0] SEL_CYCLE  = 2'd1;
  localparam logic [1:0] SEL_TXDATA = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;

  logic [31:0]    r_prog [PROG_WORDS];
  logic [31:0]    r_ram  [DATA_WORDS];
  logic [7:0]     r_fifo [4];
  logic [PAW-1:0] r_ptr;
  logic           r_load_en_d;
  logic [31:0]    r_gpio;
  logic [31:0]    r_cycle;
  logic [1:0]     r_rd_ptr;
  logic [1:0]     r_wr_ptr;
  logic [2:0]     r_count;
  logic           r_ovf;

  logic           w_ram_sel;
  logic           w_mmio_sel;
  logic [1:0]     w_mmio_idx;
  logic           w_store;
  logic           w_load_wr;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_push_req;
  logic           w_push;
  logic           w_ovf_clr;
  logic [31:0]    w_rd_data;
  logic           w_unused;

  assign w_ram_sel  = (mem_addr_bus[31:DAW+2] == '0);
  assign w_mmio_sel = (mem_addr_bus[31:4] == 28'hFFF_FFF0);
  assign w_mmio_idx = mem_addr_bus[3:2];

  // CPU stores are blocked while the loader owns the system.
  assign w_store    = mem_write_signal & ~load_en & ~reset;
  assign w_load_wr  = load_en & load_valid & ~reset;

  assign w_empty    = (r_count == 3'd0);
  assign w_full     = (r_count == 3'd4);
  assign w_pop      = ~w_empty & tx_ready;
  assign w_push_req = w_store & w_mmio_sel & (w_mmio_idx == SEL_TXDATA);
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_ovf_clr  = w_store & w_mmio_sel & (w_mmio_idx == SEL_STATUS) & mem_write_data_bus[2];

  assign w_unused   = ^{program_addr_bus[31:PAW+2], program_addr_bus[1:0], mem_addr_bus[1:0]};

  assign program_data_bus = r_prog[program_addr_bus[PAW+1:2]];
  assign load_ready       = w_load_wr;
  assign cpu_hold         = reset | load_en | r_load_en_d;
  assign gpio_out         = r_gpio;
  assign tx_valid         = ~w_empty;
  assign tx_data          = r_fifo[r_rd_ptr];

  always_comb begin
    w_rd_data = '0;
    if (w_ram_sel) begin
      w_rd_data = r_ram[mem_addr_bus[DAW+1:2]];
    end else if (w_mmio_sel) begin
      case (w_mmio_idx)
        SEL_GPIO:   w_rd_data = r_gpio;
        SEL_CYCLE:  w_rd_data = r_cycle;
        SEL_TXDATA: w_rd_data = '0;
        SEL_STATUS: w_rd_data = {26'd0, r_count, r_ovf, w_full, w_empty};
        default:    w_rd_data = '0;
      endcase
    end
  end
  assign mem_read_data_bus = w_rd_data;

  // Storage arrays survive reset; only their write enables are gated.
  always_ff @(posedge clk) begin
    if (w_load_wr) r_prog[r_ptr] <= load_data;
    if (w_store && w_ram_sel) r_ram[mem_addr_bus[DAW+1:2]] <= mem_write_data_bus;
    if (w_push) r_fifo[r_wr_ptr] <= mem_write_data_bus[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_load_en_d <= 1'b0;
      r_gpio      <= '0;
      r_cycle     <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_cycle     <= r_cycle + 32'd1;
      r_load_en_d <= load_en;
      if (!load_en) r_ptr <= '0;
      else if (load_valid) r_ptr <= r_ptr + PAW'(1);
      if (w_store && w_mmio_sel && (w_mmio_idx == SEL_GPIO)) r_gpio <= mem_write_data_bus;
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      if (w_push && !w_pop) r_count <= r_count + 3'd1;
      else if (!w_push && w_pop) r_count <= r_count - 3'd1;
      if (w_ovf_clr) r_ovf <= 1'b0;
      else if (w_push_req && !w_push) r_ovf <= 1'b1;
    end
  end

endmodule
